// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Two-flop synchroniser on rxd, start bit
//               validated at mid-bit, data bits sampled at their centres
//               (LSB first), stop bit checked for framing. Each completed
//               frame produces a one-cycle rx_valid or rx_frame_err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    // Counter must hold CLKS_PER_BIT-1; a legal CLKS_PER_BIT is at least 4.
    localparam int                 c_CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_M1  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [2:0] c_ST_WAIT_HIGH = 3'd0;
    localparam logic [2:0] c_ST_IDLE      = 3'd1;
    localparam logic [2:0] c_ST_START     = 3'd2;
    localparam logic [2:0] c_ST_DATA      = 3'd3;
    localparam logic [2:0] c_ST_STOP      = 3'd4;

    logic               r_rxd_meta;
    logic               r_rxd_s;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_frame_err;

    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         w_bit_idx_nxt;
    logic [7:0]         w_shift_nxt;
    logic [7:0]         w_data_nxt;
    logic               w_valid_nxt;
    logic               w_frame_err_nxt;

    // Two-flop synchroniser; reset low so a line held low through reset
    // keeps the receiver parked in WAIT_HIGH until it is genuinely high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_meta <= 1'b0;
            r_rxd_s    <= 1'b0;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    // State, counters, shift register and registered output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_WAIT_HIGH;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // Next-state logic: mid-bit start check, centre sampling of data/stop.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        w_valid_nxt     = 1'b0;
        w_frame_err_nxt = 1'b0;

        case (r_state)
            c_ST_WAIT_HIGH: begin
                w_cnt_nxt     = '0;
                w_bit_idx_nxt = 3'd0;
                if (r_rxd_s) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end

            c_ST_IDLE: begin
                w_cnt_nxt     = '0;
                w_bit_idx_nxt = 3'd0;
                if (!r_rxd_s) begin
                    w_state_nxt = c_ST_START;
                end
            end

            c_ST_START: begin
                if (r_cnt == c_HALF_M1) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = 3'd0;
                    // A line back high at mid-start-bit was only a glitch.
                    w_state_nxt   = r_rxd_s ? c_ST_IDLE : c_ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            c_ST_DATA: begin
                if (r_cnt == c_BIT_M1) begin
                    w_cnt_nxt              = '0;
                    w_shift_nxt[r_bit_idx] = r_rxd_s;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_nxt = 3'd0;
                        w_state_nxt   = c_ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            c_ST_STOP: begin
                if (r_cnt == c_BIT_M1) begin
                    w_cnt_nxt  = '0;
                    w_data_nxt = r_shift;
                    if (r_rxd_s) begin
                        // Re-arm at stop-bit centre so a back-to-back start
                        // edge half a bit later is still caught.
                        w_valid_nxt = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = c_ST_WAIT_HIGH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            default: begin
                w_state_nxt   = c_ST_WAIT_HIGH;
                w_cnt_nxt     = '0;
                w_bit_idx_nxt = 3'd0;
            end
        endcase
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_busy      = (r_state == c_ST_START) || (r_state == c_ST_DATA) ||
                          (r_state == c_ST_STOP);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Frames are generated from
//               the 8N1 line format; expected bytes and strobe times come
//               from the frame timing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB  = 50;
    localparam int HALF = CPB / 2;
    localparam int LAT  = HALF + 9 * CPB + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int         vq_cyc[$];
    logic [7:0] vq_data[$];
    logic       vq_busy[$];
    int         fq_cyc[$];
    logic [7:0] fq_data[$];

    int         excl_err = 0;
    int         long_err = 0;
    int         stab_err = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ferr  = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge N, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder and protocol watchers, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                vq_cyc.push_back(cyc);
                vq_data.push_back(rx_data);
                vq_busy.push_back(rx_busy);
            end
            if (rx_frame_err) begin
                fq_cyc.push_back(cyc);
                fq_data.push_back(rx_data);
            end
            if (rx_valid && rx_frame_err) excl_err <= excl_err + 1;
            if ((rx_valid && prev_valid) || (rx_frame_err && prev_ferr)) long_err <= long_err + 1;
            if ((rx_data !== prev_data) && !rx_valid && !rx_frame_err) stab_err <= stab_err + 1;
        end
        prev_valid <= rx_valid;
        prev_ferr  <= rx_frame_err;
        prev_data  <= rx_data;
    end

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n cycles; inputs change 1ns after the falling edge.
    task automatic nstep(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Drive one 8N1 frame with bit period p; returns the cycle at which the
    // start bit was driven. Leaves rxd at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input int p, input logic stopb,
                              output int c0);
        rxd = 1'b0;
        c0  = cyc;
        nstep(p);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            nstep(p);
        end
        rxd = stopb;
        nstep(p);
    endtask

    task automatic expect_frame(input string tag, input int c0, input logic [7:0] d,
                                output int t_obs);
        int         t;
        logic [7:0] v;
        logic       b;
        t_obs = -1;
        check({tag, "_nvalid"}, vq_cyc.size(), 1);
        check({tag, "_nferr"}, fq_cyc.size(), 0);
        if (vq_cyc.size() > 0) begin
            t = vq_cyc.pop_front();
            v = vq_data.pop_front();
            b = vq_busy.pop_front();
            t_obs = t;
            check({tag, "_time"}, t, c0 + 1 + LAT);
            check({tag, "_data"}, int'(v), int'(d));
            check({tag, "_busy_after"}, int'(b), 0);
        end
        while (fq_cyc.size() > 0) begin
            void'(fq_cyc.pop_front());
            void'(fq_data.pop_front());
        end
    endtask

    initial begin
        int         c0;
        int         c1;
        int         t1;
        int         t2;
        int         tx;
        logic [7:0] d;
        int         p;

        // Reset state
        nstep(5);
        check("reset_data", int'(rx_data), 0);
        check("reset_valid", int'(rx_valid), 0);
        check("reset_ferr", int'(rx_frame_err), 0);
        check("reset_busy", int'(rx_busy), 0);
        rst = 1'b0;
        nstep(10);

        // Single frame, nominal rate
        send_frame(8'h5A, CPB, 1'b1, c0);
        rxd = 1'b1;
        nstep(CPB);
        expect_frame("z5a", c0, 8'h5A, tx);

        // Back-to-back frames, zero idle
        send_frame(8'h4F, CPB, 1'b1, c0);
        expect_frame("b2b_4f", c0, 8'h4F, t1);
        send_frame(8'h54, CPB, 1'b1, c1);
        rxd = 1'b1;
        nstep(CPB);
        expect_frame("b2b_54", c1, 8'h54, t2);
        check("b2b_spacing", t2 - t1, 10 * CPB);

        // Short low glitch: rejected at the start-bit centre
        rxd = 1'b0;
        c0  = cyc;
        nstep(HALF - 3);
        rxd = 1'b1;
        nstep((c0 + 2 + HALF) - cyc);
        check("glitch_busy_before", int'(rx_busy), 1);
        nstep(1);
        check("glitch_busy_after", int'(rx_busy), 0);
        nstep(CPB);
        check("glitch_nvalid", vq_cyc.size(), 0);
        check("glitch_nferr", fq_cyc.size(), 0);
        send_frame(8'h45, CPB, 1'b1, c0);
        rxd = 1'b1;
        nstep(CPB);
        expect_frame("after_glitch", c0, 8'h45, tx);

        // Framing error, line held low afterwards
        send_frame(8'h33, CPB, 1'b0, c0);
        nstep(8 * CPB);
        check("ferr_busy_low_line", int'(rx_busy), 0);
        rxd = 1'b1;
        nstep(10);
        check("ferr_nvalid", vq_cyc.size(), 0);
        check("ferr_nferr", fq_cyc.size(), 1);
        if (fq_cyc.size() > 0) begin
            check("ferr_time", fq_cyc.pop_front(), c0 + 1 + LAT);
            check("ferr_data", int'(fq_data.pop_front()), 8'h33);
        end
        check("ferr_data_held", int'(rx_data), 8'h33);
        send_frame(8'hA5, CPB, 1'b1, c0);
        rxd = 1'b1;
        nstep(CPB);
        expect_frame("after_ferr", c0, 8'hA5, tx);

        // Reset during bit 3 with the line held low through release
        rxd = 1'b0;
        nstep(CPB);
        for (int i = 0; i < 3; i++) begin
            rxd = 1'b1;
            nstep(CPB);
        end
        rxd = 1'b0;
        nstep(CPB / 2);
        rst = 1'b1;
        nstep(1);
        rst = 1'b0;
        check("midrst_data", int'(rx_data), 0);
        check("midrst_valid", int'(rx_valid), 0);
        check("midrst_ferr", int'(rx_frame_err), 0);
        check("midrst_busy", int'(rx_busy), 0);
        nstep(3 * CPB);
        check("midrst_busy_held", int'(rx_busy), 0);
        check("midrst_nvalid", vq_cyc.size(), 0);
        check("midrst_nferr", fq_cyc.size(), 0);
        rxd = 1'b1;
        nstep(5);
        send_frame(8'h00, CPB, 1'b1, c0);
        rxd = 1'b1;
        nstep(5);
        expect_frame("rst_00", c0, 8'h00, tx);
        send_frame(8'hFF, CPB, 1'b1, c0);
        rxd = 1'b1;
        nstep(5);
        expect_frame("rst_ff", c0, 8'hFF, tx);

        // Baud tolerance: transmitter 2% slow and 2% fast
        send_frame(8'h96, CPB - 1, 1'b1, c0);
        rxd = 1'b1;
        nstep(5);
        expect_frame("fast_96", c0, 8'h96, tx);
        send_frame(8'h96, CPB + 1, 1'b1, c0);
        rxd = 1'b1;
        nstep(5);
        expect_frame("slow_96", c0, 8'h96, tx);

        // Randomised bytes, bit periods and idle gaps
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom_range(0, 255));
            p = int'($urandom_range(CPB - 1, CPB + 1));
            send_frame(d, p, 1'b1, c0);
            rxd = 1'b1;
            nstep(int'($urandom_range(1, 20)));
            expect_frame("rand", c0, d, tx);
        end

        // Global protocol properties over the whole run
        nstep(CPB);
        check("strobe_exclusive", excl_err, 0);
        check("strobe_one_cycle", long_err, 0);
        check("data_stable", stab_err, 0);
        check("no_stray_valid", vq_cyc.size(), 0);
        check("no_stray_ferr", fq_cyc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver, the receive-side counterpart of the board's UART transmitter. It uses the same bit period (CLKS_PER_BIT system clocks per bit, LSB first, one start bit, one stop bit, no parity). It synchronises the asynchronous `rxd` line, validates the start bit at mid-bit, samples each data bit at its centre, and presents each received byte with a one-cycle valid strobe. Framing errors are flagged, and the block waits for line idle before re-arming.

## Interface
- CLKS_PER_BIT, 1085: system clocks per UART bit; legal range ≥ 4. HALF = floor(CLKS_PER_BIT/2) = 542 at default.
- clk  input  1  system clock, all logic on rising edge. One clock.
- rst  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial line, idle high.
- rx_data  output  8  last received byte, held until next frame completes; reset 0x00.
- rx_valid  output  1  one-cycle pulse, rx_data newly valid; reset 0.
- rx_frame_err  output  1  one-cycle pulse, stop bit sampled low; reset 0.
- rx_busy  output  1  high in START, DATA, STOP; reset 0.

## Operation
- Input synchroniser: 2-flop chain on rxd → rxd_s. All decisions use rxd_s only.
- Counters: cnt (width ≥ clog2(CLKS_PER_BIT)) and bit_idx (3 bits). Both are cleared on every state entry.
- States:
  - WAIT_HIGH (reset state). Go to IDLE when rxd_s==1. A line held low out of reset never produces a frame.
  - IDLE. When rxd_s==0, go to START with cnt=0.
  - START. Increment cnt. At cnt==HALF-1, sample rxd_s.
    - 0: go to DATA, cnt=0, bit_idx=0.
    - 1: false start, go to IDLE; no outputs change.
  - DATA. Increment cnt. At cnt==CLKS_PER_BIT-1, sample rxd_s into shift register position bit_idx (LSB first) and clear cnt.
    - After bit_idx==7, go to STOP; otherwise bit_idx+1.
  - STOP. At cnt==CLKS_PER_BIT-1, sample rxd_s. In both cases rx_data ← shift register.
    - 1: pulse rx_valid, go to IDLE.
    - 0: pulse rx_frame_err, no rx_valid, go to WAIT_HIGH.
- The stop bit is sampled at its centre and the return to IDLE happens immediately after. A back-to-back start edge half a bit later is therefore caught.
- rx_valid and rx_frame_err are mutually exclusive and never high for more than one cycle.
- Reset mid-frame discards the partial byte, clears all outputs, and enters WAIT_HIGH.

## Timing
- Let edge k be the first clk edge that samples rxd low at the input (the start bit).
  - rxd_s low after edge k+1.
  - START entered at edge k+2.
  - Start sample at edge k+2+HALF.
  - Data bit n sampled at edge k+2+HALF+(n+1)·CLKS_PER_BIT.
  - Stop sample at edge k+2+HALF+9·CLKS_PER_BIT.
- rx_valid / rx_frame_err are high in the single cycle after the stop-sample edge. Latency is HALF + 9·CLKS_PER_BIT + 2 clocks, which is 10309 at default.
- rx_data changes on the same edge that raises rx_valid / rx_frame_err, and is stable otherwise.
- Glitch rejection: a low pulse on rxd shorter than HALF-2 clocks never leaves START via DATA.
- Baud tolerance: mid-bit sampling accepts a transmitter period of CLKS_PER_BIT ±2% without error.

## Test plan
- Send 0x5A ("Z") at 1085 clocks/bit → exactly one rx_valid pulse, 10309 clocks after the start edge; rx_data=0x5A; rx_frame_err never high.
- Send 0x4F ("O") then 0x54 ("T") with zero idle between frames → two rx_valid pulses exactly 10850 clocks apart, rx_data 0x4F then 0x54; rx_busy low for ~HALF clocks between frames.
- Drive rxd low for 300 clocks, then high → no rx_valid or rx_frame_err; rx_busy drops at the START sample point; a following 0x45 frame is received correctly.
- Send 0x33 with the stop bit driven low, hold rxd low for 5000 clocks, then release → one rx_frame_err pulse, no rx_valid, rx_data=0x33. A frame sent while the line is still low is ignored, and the next proper frame 0xA5 is received.
- Assert rst for 1 clock during bit 3 of a frame, holding rxd low through reset release → all outputs 0 and no frame until rxd has been high. Then 0x00 and 0xFF each decode correctly.
- Transmit 0x96 with a bit period of 1063, then 1107 clocks → rx_data=0x96 both times, no framing error.
